multicycle_controller: RTL and testbench

//  Multicycle successor to the single-cycle CPU controller. A Moore FSM sequences each instruction over 3-5 states.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/ctrl_aludec.sv | 23 ++
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcode/funct values, ALU operation codes and datapath mux selects.
package ctrl_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned ALUCTL_W = 3;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
      S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_JAL, S_FAULT
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

   localparam logic [SEL_W-1:0] PCSRC_ALURES = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_REGB  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

   localparam logic [SEL_W-1:0] REGDST_RT = 2'b00;
   localparam logic [SEL_W-1:0] REGDST_RD = 2'b01;
   localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;

   localparam logic [SEL_W-1:0] MTR_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] MTR_MDR    = 2'b01;
   localparam logic [SEL_W-1:0] MTR_PC     = 2'b10;

endpackage

// File: rtl/ctrl_aludec.sv
// R-type funct to ALU operation decoder; o_legal drops for unsupported funct.
module ctrl_aludec
   import ctrl_pkg::*;
(
   input  logic [FUNCT_W-1:0]  i_funct,
   output logic [ALUCTL_W-1:0] o_alucontrol,
   output logic                o_legal
);

   always_comb begin
      o_alucontrol = ALU_ADD;
      o_legal      = 1'b1;
      case (i_funct)
         FN_ADD:  o_alucontrol = ALU_ADD;
         FN_SUB:  o_alucontrol = ALU_SUB;
         FN_AND:  o_alucontrol = ALU_AND;
         FN_OR:   o_alucontrol = ALU_OR;
         FN_SLT:  o_alucontrol = ALU_SLT;
         default: o_legal      = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-sequenced multicycle CPU controller with memory handshake timeout and
// sticky fault. Define CTRL_BNE_EN to decode BNE; otherwise BNE is illegal.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter  int unsigned MEM_TIMEOUT = 16,
   localparam int unsigned WAIT_W      = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [OP_W-1:0]     op,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                iord,
   output logic                irwrite,
   output logic                memwrite,
   output logic                pcwrite,
   output logic                pcen,
   output logic [SEL_W-1:0]    pcsrc,
   output logic                alusrca,
   output logic [SEL_W-1:0]    alusrcb,
   output logic [SEL_W-1:0]    regdst,
   output logic [SEL_W-1:0]    memtoreg,
   output logic                regwrite,
   output logic [ALUCTL_W-1:0] alucontrol,
   output logic                instr_done,
   output logic                fault
);

   state_t              r_state;
   state_t              w_state_next;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic                w_timeout;
   logic                w_branch;
   logic                w_taken;
   logic [ALUCTL_W-1:0] w_funct_aluctl;
   logic                w_funct_legal;

   ctrl_aludec u_aludec (
      .i_funct      (funct),
      .o_alucontrol (w_funct_aluctl),
      .o_legal      (w_funct_legal)
   );

   // Counter restarts whenever the state changes, so every mem state starts from 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_state_next != r_state)
            r_wait_cnt <= '0;
         else if (mem_req && !mem_ready)
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
   end

   // Last allowed wait cycle; a ready in this same cycle still completes.
   assign w_timeout = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

`ifdef CTRL_BNE_EN
   assign w_taken = (op == OP_BNE) ? ~zero : zero;
`else
   assign w_taken = zero;
`endif

   assign pcen = pcwrite | (w_branch & w_taken);

   always_comb begin
      w_state_next = r_state;
      mem_req      = 1'b0;
      iord         = 1'b0;
      irwrite      = 1'b0;
      memwrite     = 1'b0;
      pcwrite      = 1'b0;
      pcsrc        = PCSRC_ALURES;
      alusrca      = 1'b0;
      alusrcb      = SRCB_REGB;
      regdst       = REGDST_RT;
      memtoreg     = MTR_ALUOUT;
      regwrite     = 1'b0;
      alucontrol   = ALU_AND;
      instr_done   = 1'b0;
      fault        = 1'b0;
      w_branch     = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alusrcb    = SRCB_FOUR;
            alucontrol = ALU_ADD;
            if (mem_ready) begin
               irwrite      = 1'b1;
               pcwrite      = 1'b1;
               w_state_next = S_DECODE;
            end else if (w_timeout) begin
               w_state_next = S_FAULT;
            end
         end
         S_DECODE: begin
            alusrcb    = SRCB_IMMSH;
            alucontrol = ALU_ADD;
            case (op)
               OP_LW, OP_SW: w_state_next = S_MEMADR;
               OP_RTYPE:     w_state_next = S_EXEC;
               OP_ADDI:      w_state_next = S_ADDIEX;
               OP_BEQ:       w_state_next = S_BRANCH;
`ifdef CTRL_BNE_EN
               OP_BNE:       w_state_next = S_BRANCH;
`else
               OP_BNE:       w_state_next = S_FAULT;
`endif
               OP_J:         w_state_next = S_JUMP;
               OP_JAL:       w_state_next = S_JAL;
               default:      w_state_next = S_FAULT;
            endcase
         end
         S_MEMADR: begin
            alusrca      = 1'b1;
            alusrcb      = SRCB_IMM;
            alucontrol   = ALU_ADD;
            w_state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            mem_req = 1'b1;
            if (mem_ready)      w_state_next = S_MEMWB;
            else if (w_timeout) w_state_next = S_FAULT;
         end
         S_MEMWB: begin
            regwrite     = 1'b1;
            memtoreg     = MTR_MDR;
            instr_done   = 1'b1;
            w_state_next = S_FETCH;
         end
         S_MEMWR: begin
            iord    = 1'b1;
            mem_req = 1'b1;
            if (mem_ready) begin
               memwrite     = 1'b1;
               instr_done   = 1'b1;
               w_state_next = S_FETCH;
            end else if (w_timeout) begin
               w_state_next = S_FAULT;
            end
         end
         S_EXEC: begin
            alusrca      = 1'b1;
            alucontrol   = w_funct_aluctl;
            w_state_next = w_funct_legal ? S_ALUWB : S_FAULT;
         end
         S_ALUWB: begin
            regdst       = REGDST_RD;
            regwrite     = 1'b1;
            instr_done   = 1'b1;
            w_state_next = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca      = 1'b1;
            alusrcb      = SRCB_IMM;
            alucontrol   = ALU_ADD;
            w_state_next = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite     = 1'b1;
            instr_done   = 1'b1;
            w_state_next = S_FETCH;
         end
         S_BRANCH: begin
            alusrca      = 1'b1;
            alucontrol   = ALU_SUB;
            pcsrc        = PCSRC_ALUOUT;
            w_branch     = 1'b1;
            instr_done   = 1'b1;
            w_state_next = S_FETCH;
         end
         S_JUMP: begin
            pcsrc        = PCSRC_JUMP;
            pcwrite      = 1'b1;
            instr_done   = 1'b1;
            w_state_next = S_FETCH;
         end
         S_JAL: begin
            pcsrc        = PCSRC_JUMP;
            pcwrite      = 1'b1;
            regwrite     = 1'b1;
            regdst       = REGDST_RA;
            memtoreg     = MTR_PC;
            instr_done   = 1'b1;
            w_state_next = S_FETCH;
         end
         S_FAULT: fault = 1'b1;
         default: w_state_next = S_FAULT;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT=4); BNE expectations
// follow CTRL_BNE_EN.
module tb_multicycle_controller;

   logic       clk;
   logic       reset_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, iord, irwrite, memwrite, pcwrite, pcen;
   logic [1:0] pcsrc, alusrcb, regdst, memtoreg;
   logic       alusrca, regwrite, instr_done, fault;
   logic [2:0] alucontrol;

   int n_pass  = 0;
   int n_total = 0;

   multicycle_controller #(.MEM_TIMEOUT(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .iord       (iord),
      .irwrite    (irwrite),
      .memwrite   (memwrite),
      .pcwrite    (pcwrite),
      .pcen       (pcen),
      .pcsrc      (pcsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alucontrol (alucontrol),
      .instr_done (instr_done),
      .fault      (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
      n_total++;
      assert (obs === want) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
   endtask

   // Advance to just after the next falling edge.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      #2;
      chk("rst_memreq",  8'(mem_req),    8'd1);
      chk("rst_alusrcb", 8'(alusrcb),    8'd1);
      chk("rst_aluctl",  8'(alucontrol), 8'd2);
      chk("rst_irwrite", 8'(irwrite),    8'd0);
      chk("rst_pcen",    8'(pcen),       8'd0);
      chk("rst_fault",   8'(fault),      8'd0);

      // LW with immediate ready
      @(negedge clk);
      reset_n = 1'b1; op = 6'b100011; mem_ready = 1'b1;
      #1;
      chk("lw_fetch_irwrite", 8'(irwrite), 8'd1);
      chk("lw_fetch_pcen",    8'(pcen),    8'd1);
      chk("lw_fetch_iord",    8'(iord),    8'd0);
      cyc();
      chk("lw_dec_alusrcb",   8'(alusrcb), 8'd3);
      chk("lw_dec_memreq",    8'(mem_req), 8'd0);
      cyc();
      chk("lw_adr_alusrcb",   8'(alusrcb), 8'd2);
      chk("lw_adr_alusrca",   8'(alusrca), 8'd1);
      cyc();
      chk("lw_rd_iord",       8'(iord),     8'd1);
      chk("lw_rd_memreq",     8'(mem_req),  8'd1);
      chk("lw_rd_regwrite",   8'(regwrite), 8'd0);
      cyc();
      chk("lw_wb_regwrite",   8'(regwrite),   8'd1);
      chk("lw_wb_memtoreg",   8'(memtoreg),   8'd1);
      chk("lw_wb_regdst",     8'(regdst),     8'd0);
      chk("lw_wb_done",       8'(instr_done), 8'd1);
      cyc();
      chk("lw_end_memreq",    8'(mem_req),    8'd1);
      chk("lw_end_done",      8'(instr_done), 8'd0);
      chk("lw_end_regwrite",  8'(regwrite),   8'd0);

      // SW with ready held low 3 cycles in MEMWR
      op = 6'b101011;
      cyc();
      cyc();
      cyc();
      mem_ready = 1'b0;
      #1;
      chk("sw_wait0_memwrite", 8'(memwrite), 8'd0);
      chk("sw_wait0_memreq",   8'(mem_req),  8'd1);
      chk("sw_wait0_iord",     8'(iord),     8'd1);
      for (int i = 1; i < 3; i++) begin
         cyc();
         chk("sw_wait_memwrite", 8'(memwrite), 8'd0);
         chk("sw_wait_fault",    8'(fault),    8'd0);
      end
      cyc();
      mem_ready = 1'b1;
      #1;
      chk("sw_ready_memwrite", 8'(memwrite),   8'd1);
      chk("sw_ready_done",     8'(instr_done), 8'd1);
      chk("sw_ready_fault",    8'(fault),      8'd0);
      cyc();
      chk("sw_end_memwrite",   8'(memwrite), 8'd0);
      chk("sw_end_memreq",     8'(mem_req),  8'd1);
      chk("sw_end_fault",      8'(fault),    8'd0);

      // BEQ taken then not taken
      op = 6'b000100; zero = 1'b1;
      cyc();
      cyc();
      chk("beq1_pcen",   8'(pcen),       8'd1);
      chk("beq1_pcsrc",  8'(pcsrc),      8'd1);
      chk("beq1_aluctl", 8'(alucontrol), 8'd6);
      chk("beq1_done",   8'(instr_done), 8'd1);
      cyc();
      chk("beq1_fetch",  8'(mem_req),    8'd1);
      zero = 1'b0;
      cyc();
      cyc();
      chk("beq0_pcen",   8'(pcen),       8'd0);
      chk("beq0_done",   8'(instr_done), 8'd1);
      cyc();
      chk("beq0_fetch",  8'(mem_req),    8'd1);

      // R-type slt
      op = 6'b000000; funct = 6'b101010;
      cyc();
      cyc();
      chk("slt_exec_aluctl",  8'(alucontrol), 8'd7);
      chk("slt_exec_alusrca", 8'(alusrca),    8'd1);
      cyc();
      chk("slt_wb_regdst",    8'(regdst),     8'd1);
      chk("slt_wb_regwrite",  8'(regwrite),   8'd1);
      cyc();

      // ADDI
      op = 6'b001000;
      cyc();
      cyc();
      chk("addi_ex_alusrcb",  8'(alusrcb),    8'd2);
      cyc();
      chk("addi_wb_regwrite", 8'(regwrite),   8'd1);
      chk("addi_wb_regdst",   8'(regdst),     8'd0);
      chk("addi_wb_done",     8'(instr_done), 8'd1);
      cyc();

      // JAL
      op = 6'b000011;
      cyc();
      cyc();
      chk("jal_pcsrc",    8'(pcsrc),    8'd2);
      chk("jal_pcen",     8'(pcen),     8'd1);
      chk("jal_regdst",   8'(regdst),   8'd2);
      chk("jal_memtoreg", 8'(memtoreg), 8'd2);
      chk("jal_regwrite", 8'(regwrite), 8'd1);
      cyc();

      // BNE with zero=0
      op = 6'b000101; zero = 1'b0;
      cyc();
      cyc();
`ifdef CTRL_BNE_EN
      chk("bne_pcen",  8'(pcen),  8'd1);
      chk("bne_fault", 8'(fault), 8'd0);
`else
      chk("bne_pcen",  8'(pcen),  8'd0);
      chk("bne_fault", 8'(fault), 8'd1);
`endif

      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst2_fault",  8'(fault),   8'd0);
      chk("rst2_memreq", 8'(mem_req), 8'd1);
      @(negedge clk);
      reset_n = 1'b1;

      // Illegal funct: sticky fault
      op = 6'b000000; funct = 6'b111111;
      #1;
      cyc();
      cyc();
      op = 6'b100011;
      cyc();
      chk("badfn_fault",  8'(fault),   8'd1);
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("badfn_hold_fault",    8'(fault),    8'd1);
         chk("badfn_hold_memreq",   8'(mem_req),  8'd0);
         chk("badfn_hold_regwrite", 8'(regwrite), 8'd0);
      end

      // Asynchronous reset mid-cycle clears the fault
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_rst_fault",   8'(fault),   8'd0);
      chk("async_rst_memreq",  8'(mem_req), 8'd1);
      chk("async_rst_alusrcb", 8'(alusrcb), 8'd1);

      // FETCH timeout: 4 waiting cycles, fault in cycle 5
      mem_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("to_c1_fault", 8'(fault), 8'd0);
      for (int i = 2; i <= 4; i++) begin
         cyc();
         chk("to_wait_fault",  8'(fault),   8'd0);
         chk("to_wait_memreq", 8'(mem_req), 8'd1);
      end
      cyc();
      chk("to_c5_fault",  8'(fault),   8'd1);
      chk("to_c5_memreq", 8'(mem_req), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
